counter_mod_n: RTL

//   Parametrised modulo-N counter; successor to the fixed mod-100 counter.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_prescaler.sv | 32 +++
 rtl/counter_mod_n.sv | 95 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the modulo-N counter.
package counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  function automatic int unsigned clamp_load(
    input int unsigned val,
    input int unsigned max
  );
    return (val > max - 1) ? max - 1 : val;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled cycles by PRESCALE into step pulses.
// Phase holds while disabled and is restarted by clear/load.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_step
);

  localparam int PH_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PRESCALE - 1);

  logic [PH_W-1:0] phase_q;
  logic            due;

  assign due    = (phase_q == PH_LAST);
  assign o_step = i_en & due;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else if (i_restart) begin
      phase_q <= '0;
    end else if (i_en) begin
      phase_q <= due ? '0 : phase_q + PH_W'(1);
    end
  end

endmodule

// File: rtl/counter_mod_n.sv
// counter_mod_n: modulo-MAX up/down counter with clear, load, tc pulse and
// saturating wrap count. Define COUNTER_PRESCALE_EN to add an enable prescaler.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int MAX      = 100,
  parameter int CNT_W    = $clog2(MAX),
  parameter int WRAP_W   = 8,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic              i_up_dn,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [CNT_W-1:0]  i_load_val,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_tc,
  output logic [WRAP_W-1:0] o_wrap_cnt
);

  localparam logic [CNT_W-1:0] TOP = CNT_W'(MAX - 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [WRAP_W-1:0] wrap_q;
  logic              tc_q;
  logic              step;
  logic              wrap_ev;
  logic [CNT_W-1:0]  load_cl;

  if (MAX < 2) begin : g_bad_max
    $error("MAX must be >= 2");
  end

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (i_en),
    .i_restart (i_clear | i_load),
    .o_step    (step)
  );
`else
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be >= 1");
  end
  assign step = i_en;
`endif

  assign load_cl = CNT_W'(clamp_load(32'(i_load_val), MAX));

  always_comb begin
    cnt_nxt = cnt_q;
    wrap_ev = 1'b0;
    if (i_up_dn == CNT_UP) begin
      wrap_ev = (cnt_q == TOP);
      cnt_nxt = wrap_ev ? '0 : cnt_q + CNT_W'(1);
    end else begin
      wrap_ev = (cnt_q == '0);
      cnt_nxt = wrap_ev ? TOP : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      wrap_q <= '0;
    end else if (i_clear) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      wrap_q <= '0;
    end else if (i_load) begin
      cnt_q <= load_cl;
      tc_q  <= 1'b0;
    end else if (step) begin
      cnt_q <= cnt_nxt;
      tc_q  <= wrap_ev;
      if (wrap_ev && wrap_q != '1) begin
        wrap_q <= wrap_q + WRAP_W'(1);
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign o_cnt      = cnt_q;
  assign o_tc       = tc_q;
  assign o_wrap_cnt = wrap_q;

endmodule
